serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
Upstream stage for the serial sequence-detector FSM. Accepts parallel words over a valid/ready handshake and shifts each word out one bit per clock on x, which drives the detector's x input directly. Emits a bit-valid strobe plus start-of-frame and end-of-frame flags. Drives an idle level of 0 between words.

Parameters:
WIDTH, 8, bits per word (legal 2..32)
MSB_FIRST, 1, 1 = din[WIDTH-1] shifted first; 0 = din[0] first
GAP, 0, idle cycles inserted after each word (legal 0..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a word
din_ready  output  1  block can accept a word this cycle
x  output  1  serial bit to the detector
x_valid  output  1  x carries a data bit this cycle
sof  output  1  x is the first bit of a word
eof  output  1  x is the last bit of a word
busy  output  1  state is not IDLE

Behaviour:
- Reset (rst low, async) forces state=IDLE, shift register=0, bit count=0, gap count=0.
- Reset output values: x=0, x_valid=0, sof=0, eof=0, busy=0, din_ready=1 (combinational from IDLE).
- Reset mid-word aborts that word. Remaining bits are lost and nothing is replayed.
- Release is async. Operation starts at the first clk edge with rst high.
- States are IDLE, SHIFT and GAP.
- Accept occurs on a clk edge where din_valid & din_ready are both 1. din is captured into the shift register and bit count is cleared.
- din_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1 & GAP==0). It never depends on din_valid.
- IDLE: on accept go to SHIFT; otherwise stay in IDLE.
- Latency: the first bit appears on x in the cycle after accept.
- SHIFT, each cycle:
  - x = current head bit (MSB or LSB per MSB_FIRST).
  - x_valid=1, sof=(cnt==0), eof=(cnt==WIDTH-1).
  - At the edge, shift toward the head and increment cnt.
- SHIFT at cnt==WIDTH-1:
  - GAP>0: go to GAP with gap count=0.
  - GAP==0 with an accept on that edge: reload and stay in SHIFT. The next word's bit 0 follows with no bubble (back-to-back).
  - GAP==0 with no accept: go to IDLE.
- GAP: x=0, x_valid=0. Stay for exactly GAP cycles, then go to IDLE. din_ready=0 throughout GAP.
- x is 0 whenever x_valid=0 (IDLE, GAP). The detector therefore sees 0s between words.
- All outputs decode from registers only, except din_ready. There is no combinational path from din or din_valid to any output.
- din and din_valid are don't-care when din_ready=0. A held din_valid is accepted on the first ready cycle.
- WIDTH=2: sof and eof are on consecutive cycles. sof and eof are never both 1 on the same cycle.
- Bit count width is clog2(WIDTH). Gap count is 4 bits. Counters saturate logic-free because they are always cleared on state entry.

Decomposition:
- Shared package feeder_pkg holds the state enum state_t {IDLE, SHIFT, GAP} with 2-bit encoding, and the legal-range constants for WIDTH and GAP.
- No sub-module. Shift register, counters and FSM stay in one flat module.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, din=8'hA0, one-cycle valid. Required response:
   - x = 1,0,1,0,0,0,0,0 on cycles 1-8 after accept.
   - sof on cycle 1, eof on cycle 8.
   - x_valid high exactly 8 cycles, then x=0 and din_ready=1.
2. MSB_FIRST=0, din=8'h05. Required: x = 1,0,1,0,0,0,0,0, i.e. LSB first.
3. GAP=0, din_valid held high with words 8'hFF then 8'h00. Required:
   - 16 consecutive x_valid cycles, x = eight 1s then eight 0s.
   - din_ready high only on the cycle with cnt=7.
4. GAP=2, back-to-back valid words. Required:
   - Exactly 2 cycles of x_valid=0 after eof, then 1 IDLE cycle of din_ready=1.
   - Next sof comes 4 cycles after the previous eof.
5. rst low at bit 3 of 8'hA5. Required:
   - Outputs go to reset values immediately, without waiting for a clock.
   - After release, a new word 8'h3C is serialized correctly from bit 0.
6. din_valid high while busy with GAP=2. Required:
   - No capture during SHIFT or GAP; the word is held by the source.
   - It is accepted on the IDLE cycle and shifted out correctly.

Source files
------------

// File: rtl/feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : feeder_pkg
// Description : Shared types and legal parameter ranges for the serial bit
//               feeder that drives the sequence-detector x input.
//               Contents:
//                 state_t     - FSM state encoding (IDLE, SHIFT, GAP), 2 bits
//                 c_WIDTH_MIN - smallest legal word width
//                 c_WIDTH_MAX - largest legal word width
//                 c_GAP_MIN   - smallest legal inter-word gap
//                 c_GAP_MAX   - largest legal inter-word gap (4-bit counter)
// Revision    : 1.0 - initial release
// ============================================================================
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int c_WIDTH_MIN = 2;
    localparam int c_WIDTH_MAX = 32;
    localparam int c_GAP_MIN   = 0;
    localparam int c_GAP_MAX   = 15;

endpackage : feeder_pkg
`default_nettype wire

// File: rtl/serial_bit_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_feeder_if
// Description : Word handshake plus serial output bundle of the bit feeder.
//               Signals:
//                 din       [WIDTH] parallel word to serialize
//                 din_valid         din holds a word
//                 din_ready         feeder can accept a word this cycle
//                 x                 serial bit to the detector
//                 x_valid           x carries a data bit this cycle
//                 sof               x is the first bit of a word
//                 eof               x is the last bit of a word
//                 busy              feeder is not idle
//               Modports:
//                 master - word source / serial observer
//                 slave  - the feeder itself
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  x,
        input  x_valid,
        input  sof,
        input  eof,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output x,
        output x_valid,
        output sof,
        output eof,
        output busy
    );

endinterface : serial_bit_feeder_if
`default_nettype wire

// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_feeder
// Description : Accepts parallel words over valid/ready and shifts them out
//               one bit per clock on x, with bit-valid, start-of-frame and
//               end-of-frame strobes. x idles at 0 between words. An optional
//               fixed gap of idle cycles follows every word.
//               Ports:
//                 clk  - rising-edge clock
//                 rst  - asynchronous, active-low reset
//                 bus  - serial_bit_feeder_if.slave (din, din_valid,
//                        din_ready, x, x_valid, sof, eof, busy)
//               Parameters:
//                 WIDTH     - bits per word (2..32), must match bus WIDTH
//                 MSB_FIRST - 1: din[WIDTH-1] first, 0: din[0] first
//                 GAP       - idle cycles after each word (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  wire                 clk,
    input  wire                 rst,
    serial_bit_feeder_if.slave  bus
);

    import feeder_pkg::*;

    // The parameter GAP shadows the state name, so that state is always
    // referenced with its package qualifier in this module.

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam bit                 c_HAS_GAP  = (GAP > 0);
    localparam logic [3:0]         c_GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_shift;
    logic [WIDTH-1:0]     w_shift_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_gap_cnt;

    logic                 w_in_shift;
    logic                 w_last;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_head;

    assign w_in_shift = (r_state == SHIFT);
    assign w_last     = w_in_shift && (r_cnt == c_CNT_LAST);

    // Ready in IDLE, and on the final bit when there is no gap so that the
    // next word follows with no bubble. Never a function of din_valid.
    assign w_ready  = (r_state == IDLE) || (w_last && !c_HAS_GAP);
    assign w_accept = bus.din_valid && w_ready;

    // Head bit selection and shift direction: the register always moves
    // toward the head so the next bit to send sits in a fixed position.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_head      = r_shift[WIDTH-1];
            assign w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head      = r_shift[0];
            assign w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    if (c_HAS_GAP) begin
                        w_state_nxt = feeder_pkg::GAP;
                    end else if (!w_accept) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            feeder_pkg::GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, shift register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;

            // A reload on the final bit takes priority over the shift so a
            // back-to-back word starts cleanly at bit 0.
            if (w_accept) begin
                r_shift <= bus.din;
                r_cnt   <= '0;
            end else if (w_in_shift) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= r_cnt + c_CNT_ONE;
            end

            // Cleared outside GAP, so it is always zero on entry.
            if (r_state == feeder_pkg::GAP) begin
                r_gap_cnt <= r_gap_cnt + 4'd1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only, except din_ready
    // ------------------------------------------------------------------
    assign bus.din_ready = w_ready;
    assign bus.x         = w_in_shift && w_head;
    assign bus.x_valid   = w_in_shift;
    assign bus.sof       = w_in_shift && (r_cnt == '0);
    assign bus.eof       = w_last;
    assign bus.busy      = (r_state != IDLE);

endmodule : serial_bit_feeder
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_bit_feeder
// Description : Directed self-checking bench for serial_bit_feeder. Four
//               instances share clock and reset:
//                 u_a - WIDTH 8, MSB first, no gap
//                 u_b - WIDTH 8, LSB first, no gap
//                 u_c - WIDTH 8, MSB first, GAP 2
//                 u_d - WIDTH 2, MSB first, no gap
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bit_feeder;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_bit_feeder_if #(.WIDTH(8)) bus_a ();
    serial_bit_feeder_if #(.WIDTH(8)) bus_b ();
    serial_bit_feeder_if #(.WIDTH(8)) bus_c ();
    serial_bit_feeder_if #(.WIDTH(2)) bus_d ();

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) u_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP(2)) u_c (
        .clk (clk), .rst (rst), .bus (bus_c.slave)
    );
    serial_bit_feeder #(.WIDTH(2), .MSB_FIRST(1), .GAP(0)) u_d (
        .clk (clk), .rst (rst), .bus (bus_d.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] seq;
        logic [7:0] seq2;
        logic [3:0] seq_d;
        int         c;
        logic       e_xv, e_x, e_rdy, e_sof, e_eof;

        bus_a.din = '0; bus_a.din_valid = 1'b0;
        bus_b.din = '0; bus_b.din_valid = 1'b0;
        bus_c.din = '0; bus_c.din_valid = 1'b0;
        bus_d.din = '0; bus_d.din_valid = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_x",       32'(bus_a.x),         32'd0);
        chk("rst_x_valid", 32'(bus_a.x_valid),   32'd0);
        chk("rst_sof",     32'(bus_a.sof),       32'd0);
        chk("rst_eof",     32'(bus_a.eof),       32'd0);
        chk("rst_busy",    32'(bus_a.busy),      32'd0);
        chk("rst_ready",   32'(bus_a.din_ready), 32'd1);
        chk("rst_ready_c", 32'(bus_c.din_ready), 32'd1);
        rst = 1'b1;

        // ---------------- test 1: A0 MSB first ----------------
        seq = 8'b1010_0000;
        bus_a.din = 8'hA0; bus_a.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_a.din_valid = 1'b0;
            chk($sformatf("t1_x[%0d]", i),     32'(bus_a.x),         32'(seq[7-i]));
            chk($sformatf("t1_xv[%0d]", i),    32'(bus_a.x_valid),   32'd1);
            chk($sformatf("t1_sof[%0d]", i),   32'(bus_a.sof),       32'(i == 0));
            chk($sformatf("t1_eof[%0d]", i),   32'(bus_a.eof),       32'(i == 7));
            chk($sformatf("t1_rdy[%0d]", i),   32'(bus_a.din_ready), 32'(i == 7));
        end
        @(negedge clk);
        chk("t1_idle_xv",  32'(bus_a.x_valid),   32'd0);
        chk("t1_idle_x",   32'(bus_a.x),         32'd0);
        chk("t1_idle_rdy", 32'(bus_a.din_ready), 32'd1);
        chk("t1_idle_bsy", 32'(bus_a.busy),      32'd0);

        // ---------------- test 2: 05 LSB first ----------------
        seq = 8'b1010_0000;
        bus_b.din = 8'h05; bus_b.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_b.din_valid = 1'b0;
            chk($sformatf("t2_x[%0d]", i),  32'(bus_b.x),       32'(seq[7-i]));
            chk($sformatf("t2_xv[%0d]", i), 32'(bus_b.x_valid), 32'd1);
        end
        @(negedge clk);
        chk("t2_idle_xv", 32'(bus_b.x_valid), 32'd0);

        // ---------------- test 3: back-to-back FF, 00 ----------------
        bus_a.din = 8'hFF; bus_a.din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) bus_a.din = 8'h00;
            if (i == 8) bus_a.din_valid = 1'b0;
            chk($sformatf("t3_x[%0d]", i),   32'(bus_a.x),         32'(i < 8));
            chk($sformatf("t3_xv[%0d]", i),  32'(bus_a.x_valid),   32'd1);
            chk($sformatf("t3_rdy[%0d]", i), 32'(bus_a.din_ready), 32'((i % 8) == 7));
            chk($sformatf("t3_sof[%0d]", i), 32'(bus_a.sof),       32'((i % 8) == 0));
            chk($sformatf("t3_eof[%0d]", i), 32'(bus_a.eof),       32'((i % 8) == 7));
        end
        @(negedge clk);
        chk("t3_idle_xv",  32'(bus_a.x_valid), 32'd0);
        chk("t3_idle_bsy", 32'(bus_a.busy),    32'd0);

        // ---------------- test 4/6: GAP=2, word held while busy ----------------
        seq  = 8'b1000_0001;   // 81
        seq2 = 8'b0110_1011;   // 6B, presented during SHIFT/GAP of 81
        bus_c.din = 8'h81; bus_c.din_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 0)  bus_c.din = 8'h6B;
            if (i == 11) bus_c.din_valid = 1'b0;
            c     = i + 1;
            e_xv  = (c >= 1 && c <= 8) || (c >= 12 && c <= 19);
            e_x   = (c <= 8) ? seq[8-c] : ((c >= 12 && c <= 19) ? seq2[19-c] : 1'b0);
            e_rdy = (c == 11) || (c == 22);
            e_sof = (c == 1) || (c == 12);
            e_eof = (c == 8) || (c == 19);
            chk($sformatf("t4_x[c%0d]", c),   32'(bus_c.x),         32'(e_x));
            chk($sformatf("t4_xv[c%0d]", c),  32'(bus_c.x_valid),   32'(e_xv));
            chk($sformatf("t4_rdy[c%0d]", c), 32'(bus_c.din_ready), 32'(e_rdy));
            chk($sformatf("t4_bsy[c%0d]", c), 32'(bus_c.busy),      32'(!e_rdy));
            chk($sformatf("t4_sof[c%0d]", c), 32'(bus_c.sof),       32'(e_sof));
            chk($sformatf("t4_eof[c%0d]", c), 32'(bus_c.eof),       32'(e_eof));
        end

        // ---------------- test 5: async reset mid-word ----------------
        seq = 8'b1010_0101;   // A5
        bus_a.din = 8'hA5; bus_a.din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_a.din_valid = 1'b0;
            chk($sformatf("t5_a5_x[%0d]", i), 32'(bus_a.x), 32'(seq[7-i]));
        end
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_xv",  32'(bus_a.x_valid),   32'd0);
        chk("t5_rst_x",   32'(bus_a.x),         32'd0);
        chk("t5_rst_sof", 32'(bus_a.sof),       32'd0);
        chk("t5_rst_bsy", 32'(bus_a.busy),      32'd0);
        chk("t5_rst_rdy", 32'(bus_a.din_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        chk("t5_rel_xv", 32'(bus_a.x_valid), 32'd0);
        seq = 8'b0011_1100;   // 3C
        bus_a.din = 8'h3C; bus_a.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_a.din_valid = 1'b0;
            chk($sformatf("t5_x[%0d]", i),   32'(bus_a.x),   32'(seq[7-i]));
            chk($sformatf("t5_sof[%0d]", i), 32'(bus_a.sof), 32'(i == 0));
            chk($sformatf("t5_eof[%0d]", i), 32'(bus_a.eof), 32'(i == 7));
        end
        @(negedge clk);
        chk("t5_idle_xv", 32'(bus_a.x_valid), 32'd0);

        // ---------------- WIDTH=2 back-to-back ----------------
        seq_d = 4'b1001;      // words 10 then 01
        bus_d.din = 2'b10; bus_d.din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus_d.din = 2'b01;
            if (i == 2) bus_d.din_valid = 1'b0;
            chk($sformatf("w2_x[%0d]", i),   32'(bus_d.x),         32'(seq_d[3-i]));
            chk($sformatf("w2_sof[%0d]", i), 32'(bus_d.sof),       32'((i % 2) == 0));
            chk($sformatf("w2_eof[%0d]", i), 32'(bus_d.eof),       32'((i % 2) == 1));
            chk($sformatf("w2_rdy[%0d]", i), 32'(bus_d.din_ready), 32'((i % 2) == 1));
        end
        @(negedge clk);
        chk("w2_idle_xv", 32'(bus_d.x_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_bit_feeder
`default_nettype wire
